// File: rtl/wrong_counter.sv
// Counts "wrong answer" events: any change on the monitored channels while armed.
// Each counted event is followed by a holdoff window; the count saturates at MAX_WRONG.
module wrong_counter #(
   parameter int CH        = 3,
   parameter int W         = 8,
   parameter int CNT_W     = 3,
   parameter int MAX_WRONG = 5,
   parameter int HOLDOFF   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              clear,
   input  logic [CH*W-1:0]   ch_data,
   output logic [CNT_W-1:0]  wrong_cnt,
   output logic              wrong_pulse,
   output logic [CH-1:0]     chg_mask,
   output logic              game_over
);

   typedef enum logic [1:0] {
      S_ARMED = 2'd0,
      S_HOLD  = 2'd1,
      S_OVER  = 2'd2
   } state_e;

   // Last holdoff count value; unused when HOLDOFF is 0 because HOLD is never entered.
   localparam logic [7:0]       HOLD_LAST = (HOLDOFF > 0) ? 8'(HOLDOFF - 1) : 8'd0;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_WRONG);

   state_e             state_q, state_d;
   logic [CH*W-1:0]    prev_q;
   logic               primed_q;
   logic [7:0]         hold_q, hold_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               pulse_q, pulse_d;
   logic [CH-1:0]      mask_q, mask_d;
   logic               over_q, over_d;
   logic [CH-1:0]      chg;
   logic               any_chg;

   always_comb begin
      chg = '0;
      for (int k = 0; k < CH; k++) begin
         chg[k] = (ch_data[k*W +: W] != prev_q[k*W +: W]);
      end
      any_chg = |chg;
   end

   // NOTE: every variable gets a default before the branches so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      mask_d  = mask_q;
      hold_d  = hold_q;

      if (clear) begin
         state_d = S_ARMED;
         cnt_d   = '0;
         mask_d  = '0;
         hold_d  = '0;
      end else if (enable) begin
         unique case (state_q)
            S_ARMED: begin
               if (primed_q && any_chg) begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  pulse_d = 1'b1;
                  mask_d  = chg;
                  hold_d  = '0;
                  if (cnt_d == CNT_MAX)  state_d = S_OVER;
                  else if (HOLDOFF > 0)  state_d = S_HOLD;
                  else                   state_d = S_ARMED;
               end
            end
            S_HOLD: begin
               if (hold_q == HOLD_LAST) begin
                  state_d = S_ARMED;
                  hold_d  = '0;
               end else begin
                  hold_d  = hold_q + 8'd1;
               end
            end
            S_OVER:  ;
            default: state_d = S_ARMED;
         endcase
      end

      over_d = (state_d == S_OVER);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_ARMED;
         prev_q   <= '0;
         primed_q <= 1'b0;
         hold_q   <= '0;
         cnt_q    <= '0;
         pulse_q  <= 1'b0;
         mask_q   <= '0;
         over_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         prev_q   <= ch_data;
         primed_q <= 1'b1;
         hold_q   <= hold_d;
         cnt_q    <= cnt_d;
         pulse_q  <= pulse_d;
         mask_q   <= mask_d;
         over_q   <= over_d;
      end
   end

   assign wrong_cnt   = cnt_q;
   assign wrong_pulse = pulse_q;
   assign chg_mask    = mask_q;
   assign game_over   = over_q;

endmodule

// File: tb/tb_wrong_counter.sv
// Directed self-checking bench for wrong_counter at default parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_wrong_counter;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        clear;
   logic [23:0] ch_data;
   logic [2:0]  wrong_cnt;
   logic        wrong_pulse;
   logic [2:0]  chg_mask;
   logic        game_over;

   int checks = 0;
   int errors = 0;

   wrong_counter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .clear       (clear),
      .ch_data     (ch_data),
      .wrong_cnt   (wrong_cnt),
      .wrong_pulse (wrong_pulse),
      .chg_mask    (chg_mask),
      .game_over   (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [2:0] cnt, input logic pulse,
                            input logic [2:0] mask, input logic over);
      check({tag, ".cnt"},   32'(wrong_cnt),   32'(cnt));
      check({tag, ".pulse"}, 32'(wrong_pulse), 32'(pulse));
      check({tag, ".mask"},  32'(chg_mask),    32'(mask));
      check({tag, ".over"},  32'(game_over),   32'(over));
   endtask

   initial begin
      rst_n   = 1'b0;
      enable  = 1'b1;
      clear   = 1'b0;
      ch_data = 24'h123456;
      #2;
      check_out("reset", 3'd0, 1'b0, 3'b000, 1'b0);

      // Priming: prev was 0, so the first edge sees a difference but must not count.
      step();
      rst_n = 1'b1;
      step();
      check_out("prime", 3'd0, 1'b0, 3'b000, 1'b0);
      step();
      check_out("prime_hold", 3'd0, 1'b0, 3'b000, 1'b0);

      // Channel 1 only.
      ch_data = ch_data ^ 24'h000100;
      step();
      check_out("ch1", 3'd1, 1'b1, 3'b010, 1'b0);
      // Holdoff: changes on the next 4 edges are ignored.
      for (int i = 0; i < 4; i++) begin
         ch_data = ch_data ^ 24'h010000;
         step();
         check_out($sformatf("hold%0d", i), 3'd1, 1'b0, 3'b010, 1'b0);
      end
      step();
      check_out("armed_idle", 3'd1, 1'b0, 3'b010, 1'b0);

      // Channels 0 and 2 together count once.
      ch_data = ch_data ^ 24'h010001;
      step();
      check_out("ch02", 3'd2, 1'b1, 3'b101, 1'b0);
      step();
      check_out("ch02_pulse_off", 3'd2, 1'b0, 3'b101, 1'b0);
      repeat (4) step();

      // Disabled: no count, but prev keeps tracking so re-enable sees nothing stale.
      enable  = 1'b0;
      ch_data = ch_data ^ 24'h000001;
      step();
      check_out("disabled", 3'd2, 1'b0, 3'b101, 1'b0);
      enable = 1'b1;
      step();
      check_out("reenable", 3'd2, 1'b0, 3'b101, 1'b0);

      // Spaced changes 3..5 reach MAX_WRONG; the 6th must not count or wrap.
      for (int n = 3; n <= 5; n++) begin
         ch_data = ch_data ^ 24'h000200;
         step();
         check_out($sformatf("evt%0d", n), 3'(n), 1'b1, 3'b010, (n == 5));
         repeat (4) step();
      end
      check_out("over_idle", 3'd5, 1'b0, 3'b010, 1'b1);
      ch_data = ch_data ^ 24'h000004;
      step();
      check_out("evt6", 3'd5, 1'b0, 3'b010, 1'b1);

      // Clear with a simultaneous change while in OVER.
      clear   = 1'b1;
      ch_data = ch_data ^ 24'h040000;
      step();
      check_out("clear", 3'd0, 1'b0, 3'b000, 1'b0);
      clear = 1'b0;
      step();
      check_out("after_clear", 3'd0, 1'b0, 3'b000, 1'b0);
      ch_data = ch_data ^ 24'h000010;
      step();
      check_out("post_clear_evt", 3'd1, 1'b1, 3'b001, 1'b0);

      // Asynchronous reset in the middle of HOLD.
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async_rst", 3'd0, 1'b0, 3'b000, 1'b0);
      step();
      rst_n   = 1'b1;
      ch_data = 24'h0A0B0C;
      step();
      check_out("reprime", 3'd0, 1'b0, 3'b000, 1'b0);
      ch_data = 24'h0A0B0D;
      step();
      check_out("rst_first_evt", 3'd1, 1'b1, 3'b001, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wrong_counter.md
WRONG_COUNTER -- requirements
Module: wrong_counter

Interface
REQ-001 Parameter CH, default 3: number of monitored answer channels, 1..8.
REQ-002 Parameter W, default 8: width of each channel, 1..16.
REQ-003 Parameter CNT_W, default 3: width of the wrong count.
REQ-004 Parameter MAX_WRONG, default 5: count at which the game ends, 1..2^CNT_W-1.
REQ-005 Parameter HOLDOFF, default 4: dead cycles after each counted event, 0..255.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 enable  input  1  counting allowed while high.
REQ-009 clear  input  1  synchronous restart of count and state.
REQ-010 ch_data  input  CH*W  packed channels; channel k occupies bits [k*W+W-1 : k*W].
REQ-011 wrong_cnt  output  CNT_W  registered wrong count.
REQ-012 wrong_pulse  output  1  one-cycle strobe per counted event.
REQ-013 chg_mask  output  CH  registered channels that changed in the counted event.
REQ-014 game_over  output  1  registered, high while in OVER.

Function
REQ-015 The block SHALL register ch_data every cycle into prev and detect change per channel as ch_data[k] != prev[k]; any_chg is the OR of all channels.
REQ-016 A primed flag SHALL clear on reset; the first cycle after reset SHALL load prev without counting, then set primed.
REQ-017 States SHALL be ARMED, HOLD and OVER; reset state ARMED.
REQ-018 ARMED: when enable=1, primed=1 and any_chg=1, the block SHALL increment wrong_cnt by 1, assert wrong_pulse the next cycle, and load chg_mask with the per-channel change bits, all in the same edge.
REQ-019 After that increment, the next state SHALL be OVER if the new count equals MAX_WRONG, else HOLD if HOLDOFF>0, else ARMED.
REQ-020 HOLD: an internal counter SHALL run HOLDOFF cycles, then return to ARMED; changes during HOLD SHALL update prev but SHALL NOT count.
REQ-021 OVER: game_over=1; wrong_cnt SHALL hold at MAX_WRONG and never wrap; changes SHALL NOT count.
REQ-022 Multiple channels changing in one cycle SHALL count as exactly one event; chg_mask SHALL show all of them.
REQ-023 With enable=0, state and count SHALL freeze (HOLD counter paused); prev SHALL still track ch_data so re-enable does not count stale changes.
REQ-024 clear=1 SHALL force wrong_cnt=0, chg_mask=0, wrong_pulse=0, state ARMED, and reload prev, from any state; clear SHALL override a simultaneous change, so no event is counted.
REQ-025 wrong_pulse SHALL be high for exactly one cycle per increment and never high in HOLD-only or OVER-only cycles.
REQ-026 Latency from the ch_data change at the sampling edge to wrong_cnt/wrong_pulse valid SHALL be 1 cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force wrong_cnt=0, wrong_pulse=0, chg_mask=0, game_over=0, prev=0, primed=0, HOLD counter=0, state ARMED, regardless of clk.
REQ-028 Reset asserted mid-HOLD or in OVER SHALL abandon the operation; after release the REQ-016 priming cycle SHALL apply.

Verification (defaults: CH=3, W=8, CNT_W=3, MAX_WRONG=5, HOLDOFF=4)
REQ-029 Release reset with ch_data=0x123456, then hold it -> no pulse, wrong_cnt=0 (priming only).
REQ-030 Change channel 1 only, enable=1 -> next cycle wrong_cnt=1, wrong_pulse=1 for 1 cycle, chg_mask=3'b010; further changes within 4 cycles are ignored.
REQ-031 Change channels 0 and 2 in the same cycle -> wrong_cnt +1 only, chg_mask=3'b101.
REQ-032 Produce 6 spaced changes -> wrong_cnt stops at 5, game_over=1 after the 5th, the 6th gives no pulse and no wrap.
REQ-033 clear=1 in the same cycle as a change while in OVER -> wrong_cnt=0, game_over=0, no pulse, state ARMED.
REQ-034 Assert rst_n=0 between clock edges during HOLD -> all outputs 0 at once; first change after release plus priming counts as 1.
